ap_txn_recorder: RTL and testbench

AP_TXN_RECORDER -- requirements
Module: ap_txn_recorder

---
 rtl/ap_txn_pkg.sv | 19 +
 rtl/ap_txn_fifo.sv | 43 ++++
 rtl/ap_txn_recorder.sv | 117 +++++++++++
 tb/tb_ap_txn_recorder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_txn_pkg.sv
// Shared types and defaults for the ap_ctrl transaction recorder.
// Record timestamps are sized for the widest supported CNT_W; narrower configs zero-extend.
package ap_txn_pkg;
  localparam int CNT_W_DEF      = 32;
  localparam int PEND_DEPTH_DEF = 4;
  localparam int REC_DEPTH_DEF  = 8;
  localparam int IDX_W          = 16;
  localparam int REC_TS_W       = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  typedef struct packed {
    logic [REC_TS_W-1:0] start_ts;
    logic [REC_TS_W-1:0] done_ts;
    logic [REC_TS_W-1:0] latency;
    logic [REC_TS_W-1:0] interval;
    logic [IDX_W-1:0]    idx;
  } rec_t;
endpackage

// File: rtl/ap_txn_fifo.sv
// Generic show-ahead synchronous FIFO; a push while full is accepted when a pop happens the same cycle.
module ap_txn_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_push_ok
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp, r_rp;
  logic             w_full, w_do_pop, w_do_push;

  assign o_empty   = (r_wp == r_rp);
  assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_push_ok = !w_full || w_do_pop;
  assign w_do_push = i_push && o_push_ok;
  assign o_dout    = r_mem[r_rp[AW-1:0]];

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wp[AW-1:0]] <= i_din;
        r_wp <= r_wp + PTR_ONE;
      end
      if (w_do_pop) r_rp <= r_rp + PTR_ONE;
    end
  end
endmodule

// File: rtl/ap_txn_recorder.sv
// Observes an ap_ctrl handshake, pairs starts with dones in order and emits
// timestamped latency/interval records through a ready/valid FIFO.
module ap_txn_recorder
  import ap_txn_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PEND_DEPTH = PEND_DEPTH_DEF,
  parameter int REC_DEPTH  = REC_DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_start_ts,
  output logic [CNT_W-1:0] rec_done_ts,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [15:0]      rec_idx,
  output logic [15:0]      drop_cnt,
  output logic             pend_ovf,
  output logic             orphan_done,
  output logic             busy,
  output logic             drained
);
  localparam logic [CNT_W-1:0] CYC_ONE = 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cyc, r_last_start;
  logic             r_have_last;
  logic [15:0]      r_idx, r_drop;
  logic             r_pend_ovf, r_orphan;

  logic             w_run, w_start, w_done;
  logic             w_pend_empty, w_pend_push, w_pend_pop, w_pend_ok;
  logic [CNT_W-1:0] w_pend_head, w_start_ts;
  logic             w_rec_form, w_rec_empty, w_rec_pop, w_rec_ok;
  rec_t             w_rec, w_head;

  assign w_run   = (r_state == ST_RUN);
  assign w_start = w_run && ap_start && ap_ready;
  assign w_done  = w_run && ap_done && ap_continue;

  // Same-cycle start+done on an empty queue bypasses it entirely.
  assign w_pend_pop  = w_done && !w_pend_empty;
  assign w_pend_push = w_start && !(w_done && w_pend_empty);
  assign w_rec_form  = w_done && (!w_pend_empty || w_start);
  assign w_start_ts  = w_pend_empty ? r_cyc : w_pend_head;

  always_comb begin
    w_rec          = '0;
    w_rec.start_ts = REC_TS_W'(w_start_ts);
    w_rec.done_ts  = REC_TS_W'(r_cyc);
    w_rec.latency  = REC_TS_W'(r_cyc - w_start_ts);
    w_rec.interval = r_have_last ? REC_TS_W'(w_start_ts - r_last_start) : '0;
    w_rec.idx      = r_idx;
  end

  ap_txn_fifo #(.WIDTH(CNT_W), .DEPTH(PEND_DEPTH)) u_pend (
    .clock(clock), .reset(reset),
    .i_push(w_pend_push), .i_din(r_cyc), .i_pop(w_pend_pop),
    .o_dout(w_pend_head), .o_empty(w_pend_empty), .o_push_ok(w_pend_ok)
  );

  ap_txn_fifo #(.WIDTH($bits(rec_t)), .DEPTH(REC_DEPTH)) u_rec (
    .clock(clock), .reset(reset),
    .i_push(w_rec_form), .i_din(w_rec), .i_pop(w_rec_pop),
    .o_dout(w_head), .o_empty(w_rec_empty), .o_push_ok(w_rec_ok)
  );

  assign rec_valid    = !w_rec_empty;
  assign w_rec_pop    = rec_valid && rec_ready;
  assign rec_start_ts = w_head.start_ts[CNT_W-1:0];
  assign rec_done_ts  = w_head.done_ts[CNT_W-1:0];
  assign rec_latency  = w_head.latency[CNT_W-1:0];
  assign rec_interval = w_head.interval[CNT_W-1:0];
  assign rec_idx      = w_head.idx;
  assign drop_cnt     = r_drop;
  assign pend_ovf     = r_pend_ovf;
  assign orphan_done  = r_orphan;
  assign busy         = !w_pend_empty;
  assign drained      = (r_state == ST_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cyc        <= '0;
      r_last_start <= '0;
      r_have_last  <= 1'b0;
      r_idx        <= '0;
      r_drop       <= '0;
      r_pend_ovf   <= 1'b0;
      r_orphan     <= 1'b0;
    end else begin
      r_cyc <= r_cyc + CYC_ONE;
      case (r_state)
        ST_IDLE:  r_state <= ST_RUN;
        ST_RUN:   if (finish) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_rec_empty) r_state <= ST_DONE;
        default:  r_state <= ST_DONE;
      endcase
      // Interval tracks every formed record, including ones dropped at the FIFO.
      if (w_rec_form) begin
        r_last_start <= w_start_ts;
        r_have_last  <= 1'b1;
        if (w_rec_ok) r_idx <= r_idx + 16'd1;
        else if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
      if (w_pend_push && !w_pend_ok) r_pend_ovf <= 1'b1;
      if (w_done && w_pend_empty && !w_start) r_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ap_txn_recorder.sv
// Scoreboard bench: stimulus queues expected records, negedge monitors pop and compare.
module tb_ap_txn_recorder;
  logic        clock = 1'b0;
  logic        reset = 1'b0, reset8 = 1'b0;
  logic        ap_start = 0, ap_ready = 0, ap_done = 0, ap_continue = 0, finish = 0, rec_ready = 0;
  logic        rec_valid, pend_ovf, orphan_done, busy, drained;
  logic [31:0] rec_start_ts, rec_done_ts, rec_latency, rec_interval;
  logic [15:0] rec_idx, drop_cnt;

  logic        s8 = 0, d8 = 0;
  logic        v8, ovf8, orph8, busy8, drn8;
  logic [7:0]  st8, dn8, lat8, int8;
  logic [15:0] idx8, drop8;

  typedef struct {
    logic [31:0] st, dn, lat, intv;
    logic [15:0] idx;
    int          when;
  } exp_t;

  exp_t exp_q[$], exp8_q[$];
  int   n_vec = 0, n_err = 0;
  int   tb_cyc = 0, cyc8 = 0;

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset)
    if (!reset) tb_cyc <= 0; else tb_cyc <= tb_cyc + 1;
  always @(posedge clock or negedge reset8)
    if (!reset8) cyc8 <= 0; else cyc8 <= cyc8 + 1;

  ap_txn_recorder dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_start_ts(rec_start_ts),
    .rec_done_ts(rec_done_ts), .rec_latency(rec_latency), .rec_interval(rec_interval),
    .rec_idx(rec_idx), .drop_cnt(drop_cnt), .pend_ovf(pend_ovf),
    .orphan_done(orphan_done), .busy(busy), .drained(drained)
  );

  ap_txn_recorder #(.CNT_W(8)) dut8 (
    .clock(clock), .reset(reset8), .ap_start(s8), .ap_ready(s8),
    .ap_done(d8), .ap_continue(d8), .finish(1'b0),
    .rec_valid(v8), .rec_ready(1'b1), .rec_start_ts(st8),
    .rec_done_ts(dn8), .rec_latency(lat8), .rec_interval(int8),
    .rec_idx(idx8), .drop_cnt(drop8), .pend_ovf(ovf8),
    .orphan_done(orph8), .busy(busy8), .drained(drn8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, tb_cyc);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_valid"}, 64'(rec_valid), 0);
    chk({tag, "_start"}, 64'(rec_start_ts), 0);
    chk({tag, "_done"}, 64'(rec_done_ts), 0);
    chk({tag, "_lat"}, 64'(rec_latency), 0);
    chk({tag, "_intv"}, 64'(rec_interval), 0);
    chk({tag, "_idx"}, 64'(rec_idx), 0);
    chk({tag, "_drop"}, 64'(drop_cnt), 0);
    chk({tag, "_ovf"}, 64'(pend_ovf), 0);
    chk({tag, "_orphan"}, 64'(orphan_done), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_drained"}, 64'(drained), 0);
  endtask

  task automatic wait_to(input bit sel8, input int n);
    int k;
    for (k = 0; k < 4000 && (sel8 ? cyc8 : tb_cyc) != n; k++) begin
      @(posedge clock); #1;
    end
    if ((sel8 ? cyc8 : tb_cyc) != n) begin
      n_vec++; n_err++;
      $display("FAIL wait_to: cycle %0d not reached", n);
    end
  endtask

  task automatic exp_push(input bit sel8, input int st, input int dn, input int lat,
                          input int intv, input int idx, input int when);
    exp_t e;
    e.st = st; e.dn = dn; e.lat = lat; e.intv = intv; e.idx = 16'(idx); e.when = when;
    if (sel8) exp8_q.push_back(e); else exp_q.push_back(e);
  endtask

  task automatic drive(input logic s, input logic d);
    ap_start = s; ap_ready = s; ap_done = d; ap_continue = d;
  endtask

  task automatic do_reset();
    drive(0, 0); finish = 0;
    reset = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1;
  endtask

  exp_t m, m8;
  always @(negedge clock) begin
    if (reset && rec_valid && rec_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rec_unexpected: got st=%0d dn=%0d idx=%0d at cyc %0d, required no record",
                 rec_start_ts, rec_done_ts, rec_idx, tb_cyc);
      end else begin
        m = exp_q.pop_front();
        if (rec_start_ts !== m.st || rec_done_ts !== m.dn || rec_latency !== m.lat ||
            rec_interval !== m.intv || rec_idx !== m.idx || tb_cyc != m.when) begin
          n_err++;
          $display("FAIL rec: got st=%0d dn=%0d lat=%0d int=%0d idx=%0d @%0d required st=%0d dn=%0d lat=%0d int=%0d idx=%0d @%0d",
                   rec_start_ts, rec_done_ts, rec_latency, rec_interval, rec_idx, tb_cyc,
                   m.st, m.dn, m.lat, m.intv, m.idx, m.when);
        end
      end
    end
    if (reset8 && v8) begin
      n_vec++;
      if (exp8_q.size() == 0) begin
        n_err++;
        $display("FAIL rec8_unexpected: got st=%0d dn=%0d at cyc8 %0d", st8, dn8, cyc8);
      end else begin
        m8 = exp8_q.pop_front();
        if (st8 !== m8.st[7:0] || dn8 !== m8.dn[7:0] || lat8 !== m8.lat[7:0] ||
            int8 !== m8.intv[7:0] || idx8 !== m8.idx || cyc8 != m8.when) begin
          n_err++;
          $display("FAIL rec8: got st=%0d dn=%0d lat=%0d int=%0d idx=%0d @%0d required st=%0d dn=%0d lat=%0d int=%0d idx=%0d @%0d",
                   st8, dn8, lat8, int8, idx8, cyc8, m8.st, m8.dn, m8.lat, m8.intv, m8.idx, m8.when);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock); #1;
    chk_rst("por");
    reset = 1;

    // single transaction, valid one cycle after done
    rec_ready = 1;
    wait_to(0, 5);  drive(1, 0);
    wait_to(0, 6);  drive(0, 0);
    wait_to(0, 12); drive(0, 1); exp_push(0, 5, 12, 7, 0, 0, 13);
    wait_to(0, 13); drive(0, 0);
    wait_to(0, 16);

    // pipelined starts and dones
    do_reset();
    wait_to(0, 10); drive(1, 0);
    wait_to(0, 13); drive(0, 0);
    wait_to(0, 15); chk("busy_inflight", 64'(busy), 1);
    wait_to(0, 20); drive(0, 1);
    exp_push(0, 10, 20, 10, 0, 0, 21);
    exp_push(0, 11, 21, 10, 1, 1, 22);
    exp_push(0, 12, 22, 10, 1, 2, 23);
    wait_to(0, 23); drive(0, 0);
    wait_to(0, 25); chk("busy_idle", 64'(busy), 0);

    // backpressure: 10 records into an 8-deep FIFO
    do_reset();
    rec_ready = 0;
    wait_to(0, 10); drive(1, 0);
    wait_to(0, 11); drive(1, 1);
    wait_to(0, 20); drive(0, 1);
    wait_to(0, 21); drive(0, 0);
    for (int k = 0; k < 8; k++) exp_push(0, 10 + k, 11 + k, 1, (k == 0) ? 0 : 1, k, 30 + k);
    wait_to(0, 25);
    chk("drop_cnt", 64'(drop_cnt), 2);
    chk("hold_valid", 64'(rec_valid), 1);
    chk("hold_start", 64'(rec_start_ts), 10);
    wait_to(0, 30); rec_ready = 1;
    wait_to(0, 40); chk("bp_empty", 64'(rec_valid), 0);

    // orphan done, then pending overflow
    do_reset();
    wait_to(0, 5);  drive(0, 1);
    wait_to(0, 6);  drive(0, 0);
    wait_to(0, 7);
    chk("orphan_set", 64'(orphan_done), 1);
    chk("orphan_norec", 64'(rec_valid), 0);
    wait_to(0, 10); drive(1, 0);
    wait_to(0, 14); chk("ovf_not_yet", 64'(pend_ovf), 0);
    wait_to(0, 15); drive(0, 0);
    wait_to(0, 16);
    chk("ovf_set", 64'(pend_ovf), 1);
    chk("ovf_busy", 64'(busy), 1);
    chk("orphan_sticky", 64'(orphan_done), 1);

    // drain to DONE, later events ignored
    do_reset();
    rec_ready = 0;
    wait_to(0, 5);  drive(1, 1);
    wait_to(0, 8);  drive(0, 0);
    exp_push(0, 5, 5, 0, 0, 0, 12);
    exp_push(0, 6, 6, 0, 1, 1, 13);
    exp_push(0, 7, 7, 0, 1, 2, 14);
    wait_to(0, 10); finish = 1;
    wait_to(0, 11); finish = 0;
    wait_to(0, 12); rec_ready = 1;
    wait_to(0, 14); chk("drained_early", 64'(drained), 0);
    wait_to(0, 17); chk("drained_set", 64'(drained), 1);
    wait_to(0, 20); drive(1, 1);
    wait_to(0, 21); drive(0, 0);
    wait_to(0, 23);
    chk("done_norec", 64'(rec_valid), 0);
    chk("done_busy", 64'(busy), 0);

    // reset asserted mid-DRAIN
    do_reset();
    rec_ready = 0;
    wait_to(0, 5);  drive(1, 1);
    wait_to(0, 7);  drive(0, 0);
    wait_to(0, 10); finish = 1;
    wait_to(0, 11); finish = 0;
    wait_to(0, 12); drive(0, 1);
    wait_to(0, 13); drive(0, 0);
    wait_to(0, 14);
    chk("drain_hold", 64'(drained), 0);
    chk("drain_valid", 64'(rec_valid), 1);
    chk("drain_no_orphan", 64'(orphan_done), 0);
    #2 reset = 0;
    #1 chk_rst("mid_drain");
    repeat (2) @(posedge clock);
    #1 reset = 1;
    wait_to(0, 5);
    chk("post_rst_valid", 64'(rec_valid), 0);
    chk("post_rst_drained", 64'(drained), 0);
    rec_ready = 1;

    // 8-bit counter wrap
    @(posedge clock); #1 reset8 = 1;
    wait_to(1, 250); s8 = 1;
    wait_to(1, 251); s8 = 0;
    wait_to(1, 260); d8 = 1; exp_push(1, 250, 4, 10, 0, 0, 261);
    wait_to(1, 261); d8 = 0;
    wait_to(1, 265);
    chk("wrap_empty", 64'(v8), 0);

    chk("sb_empty", 64'(exp_q.size() + exp8_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
